// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath: IEEE-754 single fields and packer FSM states.
package cordic_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } packer_state_t;

endpackage

// File: rtl/packer_round.sv
// Round-to-nearest-even of a normalised magnitude onto a 23-bit mantissa (used with PACKER_ROUND_EN).
import cordic_pkg::*;

module packer_round (
    input  logic [8:0]  exp_in,
    input  logic [31:0] mag,
    output logic [7:0]  exp_out,
    output logic [22:0] mant_out
);

    logic        round_up;
    logic [23:0] sum;
    logic        unused_bits;

    // mag[31] is the hidden bit; mag[7:0] are the guard bits dropped from the mantissa.
    assign round_up = (mag[7:0] > 8'h80) || ((mag[7:0] == 8'h80) && mag[8]);
    assign sum      = {1'b0, mag[30:8]} + {23'd0, round_up};

    // A carry out of the mantissa leaves it all zero and bumps the exponent.
    assign mant_out    = sum[22:0];
    assign exp_out     = exp_in[7:0] + {7'd0, sum[23]};
    assign unused_bits = ^{exp_in[8], mag[31]};

endmodule

// File: rtl/packer.sv
// Fixed-point to IEEE-754 single converter with iterative one-bit-per-clock normalisation.
// Define PACKER_ROUND_EN for round-to-nearest-even; the default build truncates.
import cordic_pkg::*;

module packer #(
    parameter int FRACTIONAL_BITS = 30,
    parameter bit SIGNED          = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam logic [8:0] EXP_INIT = 9'(FP_BIAS + 31 - FRACTIONAL_BITS);

    packer_state_t state, state_next;
    logic [31:0]   mag;
    logic [8:0]    exp_r;
    logic          sign_r;
    logic          in_neg;
    logic [31:0]   abs_in;
    logic [7:0]    rnd_exp;
    logic [22:0]   rnd_mant;
    fp32_t         result;

    // The most negative input negates to itself, which reads correctly as an unsigned magnitude.
    assign in_neg = SIGNED && in_data[31];
    assign abs_in = in_neg ? (~in_data + 32'd1) : in_data;

`ifdef PACKER_ROUND_EN
    packer_round u_round (
        .exp_in  (exp_r),
        .mag     (mag),
        .exp_out (rnd_exp),
        .mant_out(rnd_mant)
    );
`else
    logic unused_bits;
    assign rnd_exp     = exp_r[7:0];
    assign rnd_mant    = mag[30:8];
    assign unused_bits = ^{exp_r[8], mag[7:0]};
`endif

    assign result.sign = sign_r;
    assign result.exp  = rnd_exp;
    assign result.mant = rnd_mant;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (abs_in == 32'd0) ? DONE : NORM;
            NORM:    if (mag[31]) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag      <= '0;
            exp_r    <= '0;
            sign_r   <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_neg;
                        mag    <= abs_in;
                        exp_r  <= EXP_INIT;
                        // Zero bypasses normalisation and never produces -0.
                        if (abs_in == 32'd0) out_data <= '0;
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag   <= mag << 1;
                        exp_r <= exp_r - 9'd1;
                    end else begin
                        out_data <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packer.sv
// Bench for packer: unsigned and signed instances checked against an arithmetic float model.
module tb_packer;

    localparam int FB = 30;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [31:0] in_data  [2];
    logic [31:0] out_data [2];

    int checks = 0;
    int errors = 0;

    packer #(.FRACTIONAL_BITS(FB), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
    );

    packer #(.FRACTIONAL_BITS(FB), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    // Reference: value = x / 2^FB, expressed as sign * 1.m * 2^e from the position of the top set bit.
    function automatic logic [31:0] ref_fp(input logic [31:0] x, input bit sgn, output int lat);
        bit     s;
        longint v, m24, rem, half;
        int     p, e, sh;
        s = sgn && x[31];
        v = s ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
        if (v == 0) begin
            lat = 1;
            return 32'h0;
        end
        p = 31;
        while (((v >> p) & 64'd1) == 0) p--;
        lat = (31 - p) + 2;
        e = 127 + p - FB;
        if (p > 23) begin
            sh   = p - 23;
            m24  = v >> sh;
            rem  = v & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
`ifdef PACKER_ROUND_EN
            if (rem > half || (rem == half && m24[0])) m24 = m24 + 1;
            if (m24 == (64'd1 << 24)) begin
                m24 = 64'd1 << 23;
                e   = e + 1;
            end
`else
            if (rem > half) m24 = m24 + 0;
`endif
        end else begin
            m24 = v << (23 - p);
        end
        return {s, 8'(e), 23'(m24)};
    endfunction

    task automatic convert(input int k, input logic [31:0] d, input logic [31:0] want,
                           input int want_lat, input int hold, input bit intrude, input string tag);
        int lat;
        int n;
        n = 0;
        while (in_ready[k] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".in_ready_idle"}, 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 1;
        if (intrude) begin
            in_valid[k] = 1'b1;
            in_data[k]  = ~d;
        end
        while (out_valid[k] !== 1'b1 && lat < 40) begin
            if (intrude) check({tag, ".in_ready_busy"}, 32'(in_ready[k]), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        in_valid[k] = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(want_lat));
        check({tag, ".out_data"}, out_data[k], want);
        check({tag, ".in_ready_done"}, 32'(in_ready[k]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(out_valid[k]), 32'd1);
            check({tag, ".hold_data"}, out_data[k], want);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check({tag, ".valid_drop"}, 32'(out_valid[k]), 32'd0);
        check({tag, ".in_ready_back"}, 32'(in_ready[k]), 32'd1);
    endtask

    initial begin
        logic [31:0] d, want;
        int          lat, k;
        in_valid  = '0;
        out_ready = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data0", out_data[0], 32'h0);
        check("rst.out_data1", out_data[1], 32'h0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready_rel", 32'(in_ready), 32'd3);

        convert(0, 32'h40000000, 32'h3F800000, 3, 5, 1'b0, "one");
        convert(0, 32'h80000000, 32'h40000000, 2, 0, 1'b0, "two");
        convert(0, 32'h00000001, 32'h30800000, 33, 0, 1'b0, "min");
        convert(0, 32'h00000000, 32'h00000000, 1, 1, 1'b0, "zero");
`ifdef PACKER_ROUND_EN
        convert(0, 32'h400001FF, 32'h3F800004, 3, 0, 1'b1, "rnd_a");
        convert(0, 32'hFFFFFFFF, 32'h40800000, 2, 0, 1'b0, "rnd_carry");
`else
        convert(0, 32'h400001FF, 32'h3F800003, 3, 0, 1'b1, "rnd_a");
        convert(0, 32'hFFFFFFFF, 32'h407FFFFF, 2, 0, 1'b0, "rnd_carry");
`endif
        convert(1, 32'hC0000000, 32'hBF800000, 3, 2, 1'b0, "s_neg_one");
        convert(1, 32'h20000000, 32'h3F000000, 4, 0, 1'b1, "s_half");
        convert(1, 32'h80000000, 32'hC0000000, 2, 0, 1'b0, "s_most_neg");
        convert(1, 32'h00000000, 32'h00000000, 1, 0, 1'b0, "s_zero");

        // Abort a long normalisation with an asynchronous reset.
        convert(0, 32'h40000000, 32'h3F800000, 3, 0, 1'b0, "pre_abort");
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h00000001;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort.out_valid", 32'(out_valid[0]), 32'd0);
        check("abort.out_data", out_data[0], 32'h0);
        check("abort.in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort.in_ready_rel", 32'(in_ready[0]), 32'd1);
        repeat (3) @(posedge clk); #1;
        check("abort.no_output", 32'(out_valid[0]), 32'd0);
        convert(0, 32'h20000000, 32'h3F000000, 4, 0, 1'b0, "post_abort");

        for (int i = 0; i < 160; i++) begin
            k = i % 2;
            d = $urandom;
            d = d >> $urandom_range(0, 31);
            if (k == 1 && $urandom_range(0, 1) == 1) d = -d;
            if ($urandom_range(0, 15) == 0) d = 32'h0;
            want = ref_fp(d, k[0], lat);
            convert(k, d, want, lat, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
